// File: rtl/block_map_ctrl.sv
// block_map_ctrl: maps block addresses onto a small set of SRAM slots.
// Lookup is combinational. On a miss it picks a victim slot, hands a swap
// command to an external swap engine and installs the new block once the
// engine reports completion.
module block_map_ctrl #(
   parameter int NumPorts  = 2,
   parameter int NumSlots  = 4,
   parameter int AddrWidth = 21,
   parameter int Policy    = 0
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 enable_i,
   input  logic                                 flush_i,
   input  logic [NumPorts-1:0]                  req_valid_i,
   input  logic [NumPorts*AddrWidth-1:0]        req_addr_i,
   output logic [NumPorts-1:0]                  hit_o,
   output logic [NumPorts*$clog2(NumSlots)-1:0] slot_idx_o,
   output logic                                 block_o,
   output logic                                 swap_valid_o,
   input  logic                                 swap_ready_i,
   output logic [$clog2(NumSlots)-1:0]          swap_slot_o,
   output logic [AddrWidth-1:0]                 swap_old_addr_o,
   output logic                                 swap_old_valid_o,
   output logic [AddrWidth-1:0]                 swap_new_addr_o,
   input  logic                                 swap_done_i
);

   localparam int IdxW = $clog2(NumSlots);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      FILL  = 2'd3
   } state_e;

   // Sequencer state and captured swap command
   state_e               state_q, state_d;
   logic [AddrWidth-1:0] new_addr_q, new_addr_d;
   logic [AddrWidth-1:0] old_addr_q, old_addr_d;
   logic                 old_valid_q, old_valid_d;
   logic [IdxW-1:0]      victim_q, victim_d;

   // Slot table and replacement state
   logic [NumSlots-1:0]  valid_q, valid_d;
   logic [AddrWidth-1:0] tag_q [NumSlots];
   logic [AddrWidth-1:0] tag_d [NumSlots];
   logic [IdxW-1:0]      age_q [NumSlots];
   logic [IdxW-1:0]      age_d [NumSlots];
   logic [IdxW-1:0]      rr_q, rr_d;

   // Combinational helpers
   logic [NumPorts-1:0]  miss_s;
   logic [AddrWidth-1:0] miss_addr_s;
   logic [IdxW-1:0]      hit_slot_s;
   logic                 free_found_s;
   logic [IdxW-1:0]      free_slot_s;
   logic [IdxW-1:0]      lru_slot_s;
   logic [IdxW-1:0]      victim_s;
   logic                 touch_s;
   logic [IdxW-1:0]      touch_slot_s;

   // Per-port lookup: a port hits when its address matches any valid slot.
   // Tags of valid slots are unique, so the lowest matching slot is the only one.
   always_comb begin
      hit_o      = '0;
      slot_idx_o = '0;
      for (int p = 0; p < NumPorts; p++) begin
         for (int s = NumSlots - 1; s >= 0; s--) begin
            if (req_valid_i[p] && valid_q[s] &&
                (tag_q[s] == req_addr_i[p*AddrWidth +: AddrWidth])) begin
               hit_o[p]                     = 1'b1;
               slot_idx_o[p*IdxW +: IdxW]   = IdxW'(s);
            end else begin
               slot_idx_o[p*IdxW +: IdxW]   = slot_idx_o[p*IdxW +: IdxW];
            end
         end
      end
   end

   // A miss only counts while swapping is enabled.
   assign miss_s = {NumPorts{enable_i}} & req_valid_i & ~hit_o;

   // Lowest-index missing port supplies the block to load; lowest-index
   // hitting port supplies the slot that counts as recently used.
   always_comb begin
      miss_addr_s = '0;
      hit_slot_s  = '0;
      for (int p = NumPorts - 1; p >= 0; p--) begin
         miss_addr_s = miss_s[p] ? req_addr_i[p*AddrWidth +: AddrWidth] : miss_addr_s;
         hit_slot_s  = hit_o[p]  ? slot_idx_o[p*IdxW +: IdxW]           : hit_slot_s;
      end
   end

   // Victim choice: an empty slot first, otherwise the replacement policy.
   always_comb begin
      free_found_s = 1'b0;
      free_slot_s  = '0;
      lru_slot_s   = '0;
      for (int s = NumSlots - 1; s >= 0; s--) begin
         free_found_s = free_found_s | ~valid_q[s];
         free_slot_s  = valid_q[s] ? free_slot_s : IdxW'(s);
         lru_slot_s   = (age_q[s] == IdxW'(NumSlots - 1)) ? IdxW'(s) : lru_slot_s;
      end
      if (free_found_s) begin
         victim_s = free_slot_s;
      end else if (Policy == 1) begin
         victim_s = lru_slot_s;
      end else begin
         victim_s = rr_q;
      end
   end

   // Swap sequencer: next state, table writes, capture of the swap command.
   always_comb begin
      state_d      = state_q;
      new_addr_d   = new_addr_q;
      old_addr_d   = old_addr_q;
      old_valid_d  = old_valid_q;
      victim_d     = victim_q;
      valid_d      = valid_q;
      tag_d        = tag_q;
      rr_d         = rr_q;
      touch_s      = 1'b0;
      touch_slot_s = '0;
      case (state_q)
         IDLE: begin
            if (|miss_s) begin
               new_addr_d  = miss_addr_s;
               victim_d    = victim_s;
               old_addr_d  = tag_q[victim_s];
               old_valid_d = valid_q[victim_s];
               state_d     = ISSUE;
            end else begin
               touch_s      = |hit_o;
               touch_slot_s = hit_slot_s;
               // Flush only lands when no swap is being started.
               valid_d      = flush_i ? '0 : valid_q;
            end
         end
         ISSUE: begin
            state_d = swap_ready_i ? WAIT : ISSUE;
         end
         WAIT: begin
            state_d = swap_done_i ? FILL : WAIT;
         end
         FILL: begin
            tag_d[victim_q]   = new_addr_q;
            valid_d[victim_q] = 1'b1;
            // The pointer only moves past slots that were actually evicted.
            if ((Policy == 0) && old_valid_q) begin
               rr_d = rr_q + IdxW'(1);
            end else begin
               rr_d = rr_q;
            end
            touch_s      = 1'b1;
            touch_slot_s = victim_q;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // LRU ages: the touched slot becomes youngest, everything younger than
   // it ages by one, so the ages stay a permutation of 0..NumSlots-1.
   always_comb begin
      age_d = age_q;
      if ((Policy == 1) && touch_s) begin
         for (int s = 0; s < NumSlots; s++) begin
            if (IdxW'(s) == touch_slot_s) begin
               age_d[s] = '0;
            end else if (age_q[s] < age_q[touch_slot_s]) begin
               age_d[s] = age_q[s] + IdxW'(1);
            end else begin
               age_d[s] = age_q[s];
            end
         end
      end else begin
         age_d = age_q;
      end
   end

   // State registers with synchronous reset; reset wins even mid-swap.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         new_addr_q  <= '0;
         old_addr_q  <= '0;
         old_valid_q <= 1'b0;
         victim_q    <= '0;
         valid_q     <= '0;
         rr_q        <= '0;
         for (int s = 0; s < NumSlots; s++) begin
            tag_q[s] <= '0;
            age_q[s] <= IdxW'(s);
         end
      end else begin
         state_q     <= state_d;
         new_addr_q  <= new_addr_d;
         old_addr_q  <= old_addr_d;
         old_valid_q <= old_valid_d;
         victim_q    <= victim_d;
         valid_q     <= valid_d;
         rr_q        <= rr_d;
         tag_q       <= tag_d;
         age_q       <= age_d;
      end
   end

   // Swap command comes straight from the captured registers, so it is
   // stable for as long as the engine stalls.
   assign swap_valid_o     = (state_q == ISSUE);
   assign swap_slot_o      = victim_q;
   assign swap_old_addr_o  = old_addr_q;
   assign swap_old_valid_o = old_valid_q;
   assign swap_new_addr_o  = new_addr_q;
   assign block_o          = (state_q == IDLE) ? (|miss_s) : 1'b1;

endmodule

// File: tb/tb_block_map_ctrl.sv
// Bench for block_map_ctrl: one round-robin and one LRU instance, each
// checked against a slot/recency-list model kept in the bench.
module tb_block_map_ctrl;
   localparam int NP = 2;
   localparam int NS = 4;
   localparam int AW = 21;
   localparam int IW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             en [2];
   logic             fl [2];
   logic             srdy [2];
   logic             sdone [2];
   logic [NP-1:0]    rv [2];
   logic [NP*AW-1:0] ra [2];
   logic [NP-1:0]    hit [2];
   logic [NP*IW-1:0] sidx [2];
   logic             blk [2];
   logic             sv [2];
   logic             sov [2];
   logic [IW-1:0]    sslot [2];
   logic [AW-1:0]    sold [2];
   logic [AW-1:0]    snew [2];

   block_map_ctrl #(.NumPorts(NP), .NumSlots(NS), .AddrWidth(AW), .Policy(0)) u_rr (
      .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .flush_i(fl[0]),
      .req_valid_i(rv[0]), .req_addr_i(ra[0]), .hit_o(hit[0]), .slot_idx_o(sidx[0]),
      .block_o(blk[0]), .swap_valid_o(sv[0]), .swap_ready_i(srdy[0]),
      .swap_slot_o(sslot[0]), .swap_old_addr_o(sold[0]), .swap_old_valid_o(sov[0]),
      .swap_new_addr_o(snew[0]), .swap_done_i(sdone[0]));

   block_map_ctrl #(.NumPorts(NP), .NumSlots(NS), .AddrWidth(AW), .Policy(1)) u_lru (
      .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .flush_i(fl[1]),
      .req_valid_i(rv[1]), .req_addr_i(ra[1]), .hit_o(hit[1]), .slot_idx_o(sidx[1]),
      .block_o(blk[1]), .swap_valid_o(sv[1]), .swap_ready_i(srdy[1]),
      .swap_slot_o(sslot[1]), .swap_old_addr_o(sold[1]), .swap_old_valid_o(sov[1]),
      .swap_new_addr_o(snew[1]), .swap_done_i(sdone[1]));

   // Reference model: per instance, slot contents, rr pointer, recency list
   logic [AW-1:0] m_tag [2][NS];
   bit            m_val [2][NS];
   int            m_rr  [2];
   int            m_ord [2][NS];   // slot numbers, most recently used first

   int n_tests = 0;
   int n_fail  = 0;
   int hs_cnt [2] = '{0, 0};

   logic [IW-1:0] obs_slot [2];
   logic [AW-1:0] obs_old [2];
   logic [AW-1:0] obs_new [2];
   logic          obs_ov [2];

   // Independent count of accepted swap commands per instance
   always @(posedge clk) begin
      if (sv[0] && srdy[0]) hs_cnt[0] <= hs_cnt[0] + 1;
      if (sv[1] && srdy[1]) hs_cnt[1] <= hs_cnt[1] + 1;
   end

   // Watchdog
   initial begin
      #3000000;
      $display("FAIL watchdog: time %0t reached, limit 3000000", $time);
      $fatal(1);
   end

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         m_rr[k] = 0;
         for (int s = 0; s < NS; s++) begin
            m_tag[k][s] = '0;
            m_val[k][s] = 1'b0;
            m_ord[k][s] = s;
         end
      end
   endfunction

   function automatic int model_find(int k, logic [AW-1:0] a);
      for (int s = 0; s < NS; s++)
         if (m_val[k][s] && m_tag[k][s] == a) return s;
      return -1;
   endfunction

   function automatic void model_touch(int k, int s);
      int pos = 0;
      for (int i = 0; i < NS; i++)
         if (m_ord[k][i] == s) pos = i;
      for (int i = pos; i > 0; i--)
         m_ord[k][i] = m_ord[k][i-1];
      m_ord[k][0] = s;
   endfunction

   function automatic int model_victim(int k);
      for (int s = 0; s < NS; s++)
         if (!m_val[k][s]) return s;
      return (k == 0) ? m_rr[k] : m_ord[k][NS-1];
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      return AW'(32'h100 + $urandom_range(0, 6));
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b0; fl[k] = 1'b0; rv[k] = '0; ra[k] = '0;
         srdy[k] = 1'b0; sdone[k] = 1'b0;
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   // Plays the swap engine for one command; entered in the first ISSUE cycle.
   task automatic do_swap(int k, int v, logic [AW-1:0] oa, logic ov, logic [AW-1:0] na, int rdy_wait);
      int w  = (rdy_wait < 0) ? int'($urandom_range(0, 3)) : rdy_wait;
      int dw = $urandom_range(0, 3);
      for (int i = 0; i <= w; i++) begin
         srdy[k]  = (i == w);
         sdone[k] = 1'($urandom_range(0, 1));
         en[k]    = 1'($urandom_range(0, 1));
         fl[k]    = 1'($urandom_range(0, 1));
         rv[k]    = NP'($urandom_range(0, 3));
         ra[k]    = {rand_addr(), rand_addr()};
         #3;
         n_tests++;
         if (sv[k] !== 1'b1 || blk[k] !== 1'b1 || sslot[k] !== IW'(v) || sov[k] !== ov ||
             snew[k] !== na || (ov && sold[k] !== oa)) begin
            n_fail++;
            $display("FAIL issue[%0d] cyc%0d: valid=%b block=%b slot=%0d old=%h ov=%b new=%h, want 1 1 %0d %h %b %h",
                     k, i, sv[k], blk[k], sslot[k], sold[k], sov[k], snew[k], v, oa, ov, na);
         end
         obs_slot[k] = sslot[k]; obs_old[k] = sold[k]; obs_ov[k] = sov[k]; obs_new[k] = snew[k];
         @(posedge clk); #1;
      end
      for (int i = 0; i <= dw; i++) begin
         srdy[k]  = 1'($urandom_range(0, 1));
         sdone[k] = (i == dw);
         #3;
         n_tests++;
         if (sv[k] !== 1'b0 || blk[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL wait[%0d]: valid=%b block=%b, want 0 1", k, sv[k], blk[k]);
         end
         @(posedge clk); #1;
      end
      srdy[k] = 1'b0; sdone[k] = 1'b0;
      #3;
      n_tests++;
      if (sv[k] !== 1'b0 || blk[k] !== 1'b1) begin
         n_fail++;
         $display("FAIL fill[%0d]: valid=%b block=%b, want 0 1", k, sv[k], blk[k]);
      end
      @(posedge clk); #1;
      if (k == 0 && m_val[k][v]) m_rr[k] = (m_rr[k] + 1) % NS;
      m_tag[k][v] = na;
      m_val[k][v] = 1'b1;
      model_touch(k, v);
   endtask

   // One IDLE cycle with the given request; runs the whole swap if it misses.
   task automatic idle_cycle(int k, logic e, logic f, logic [NP-1:0] r,
                             logic [AW-1:0] a0, logic [AW-1:0] a1, int rdy_wait);
      logic [AW-1:0]    a [NP];
      logic [NP-1:0]    eh;
      logic [NP*IW-1:0] ei;
      logic [NP*IW-1:0] msk;
      logic             eb;
      int               s, mp, hp, v;
      a[0] = a0; a[1] = a1;
      en[k] = e; fl[k] = f; rv[k] = r; ra[k] = {a1, a0};
      srdy[k] = 1'($urandom_range(0, 1)); sdone[k] = 1'($urandom_range(0, 1));
      eh = '0; ei = '0; msk = '0; mp = -1; hp = -1;
      for (int p = NP - 1; p >= 0; p--) begin
         s = model_find(k, a[p]);
         if (r[p]) msk[p*IW +: IW] = '1;
         if (r[p] && s >= 0) begin
            eh[p] = 1'b1; ei[p*IW +: IW] = IW'(s); hp = p;
         end else if (e && r[p]) begin
            mp = p;
         end
      end
      eb = (mp >= 0) ? 1'b1 : 1'b0;
      #3;
      n_tests++;
      if (hit[k] !== eh || (sidx[k] & msk) !== ei || blk[k] !== eb || sv[k] !== 1'b0) begin
         n_fail++;
         $display("FAIL idle[%0d]: hit=%b idx=%h block=%b valid=%b, want %b %h %b 0",
                  k, hit[k], sidx[k] & msk, blk[k], sv[k], eh, ei, eb);
      end
      @(posedge clk); #1;
      if (mp >= 0) begin
         v = model_victim(k);
         do_swap(k, v, m_tag[k][v], m_val[k][v], a[mp], rdy_wait);
      end else begin
         if (hp >= 0) model_touch(k, model_find(k, a[hp]));
         if (f) for (int i = 0; i < NS; i++) m_val[k][i] = 1'b0;
      end
   endtask

   task automatic test_reset();
      do_reset();
      #3;
      for (int k = 0; k < 2; k++) begin
         n_tests++;
         if (sv[k] !== 1'b0 || sslot[k] !== 2'd0 || sold[k] !== 21'd0 || sov[k] !== 1'b0 ||
             snew[k] !== 21'd0 || blk[k] !== 1'b0 || hit[k] !== 2'b00) begin
            n_fail++;
            $display("FAIL reset[%0d]: valid=%b slot=%0d old=%h ov=%b new=%h block=%b hit=%b, want all 0",
                     k, sv[k], sslot[k], sold[k], sov[k], snew[k], blk[k], hit[k]);
         end
      end
      en[0] = 1'b1; rv[0] = 2'b01; ra[0] = {21'h0, 21'h5};
      #1;
      n_tests++;
      if (blk[0] !== 1'b1 || hit[0] !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_miss: block=%b hit=%b, want 1 00", blk[0], hit[0]);
      end
      rv[0] = 2'b00;
      @(posedge clk); #1;
   endtask

   task automatic test_cold_miss();
      int h0;
      do_reset();
      h0 = hs_cnt[0];
      idle_cycle(0, 1'b1, 1'b0, 2'b01, 21'h00123, 21'h0, 2);
      n_tests++;
      if (obs_slot[0] !== 2'd0 || obs_ov[0] !== 1'b0 || obs_new[0] !== 21'h00123 || hs_cnt[0] - h0 != 1) begin
         n_fail++;
         $display("FAIL cold_miss: slot=%0d ov=%b new=%h hs=%0d, want 0 0 00123 1",
                  obs_slot[0], obs_ov[0], obs_new[0], hs_cnt[0] - h0);
      end
      en[0] = 1'b1; rv[0] = 2'b01; ra[0] = {21'h0, 21'h00123};
      #3;
      n_tests++;
      if (hit[0] !== 2'b01 || sidx[0][IW-1:0] !== 2'd0 || blk[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL cold_hit: hit=%b idx=%0d block=%b, want 01 0 0", hit[0], sidx[0][IW-1:0], blk[0]);
      end
      @(posedge clk); #1;
      model_touch(0, 0);
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 4; i++) idle_cycle(0, 1'b1, 1'b0, 2'b01, AW'(32'h10 + i), 21'h0, -1);
      idle_cycle(0, 1'b1, 1'b0, 2'b01, 21'h20, 21'h0, -1);
      n_tests++;
      if (obs_slot[0] !== 2'd0 || obs_old[0] !== 21'h10 || obs_ov[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rr_first: slot=%0d old=%h ov=%b, want 0 10 1", obs_slot[0], obs_old[0], obs_ov[0]);
      end
      idle_cycle(0, 1'b1, 1'b0, 2'b01, 21'h21, 21'h0, -1);
      n_tests++;
      if (obs_slot[0] !== 2'd1 || obs_old[0] !== 21'h11 || obs_ov[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rr_second: slot=%0d old=%h ov=%b, want 1 11 1", obs_slot[0], obs_old[0], obs_ov[0]);
      end
   endtask

   task automatic test_lru();
      do_reset();
      for (int i = 0; i < 4; i++) idle_cycle(1, 1'b1, 1'b0, 2'b01, AW'(32'h10 + i), 21'h0, -1);
      idle_cycle(1, 1'b1, 1'b0, 2'b01, 21'h10, 21'h0, -1);
      idle_cycle(1, 1'b1, 1'b0, 2'b01, 21'h20, 21'h0, -1);
      n_tests++;
      if (obs_slot[1] !== 2'd1 || obs_old[1] !== 21'h11 || obs_ov[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL lru_victim: slot=%0d old=%h ov=%b, want 1 11 1", obs_slot[1], obs_old[1], obs_ov[1]);
      end
   endtask

   task automatic test_same_addr();
      int h0;
      do_reset();
      h0 = hs_cnt[0];
      idle_cycle(0, 1'b1, 1'b0, 2'b11, 21'h55, 21'h55, -1);
      en[0] = 1'b1; rv[0] = 2'b11; ra[0] = {21'h55, 21'h55};
      #3;
      n_tests++;
      if (hs_cnt[0] - h0 != 1 || hit[0] !== 2'b11 || sidx[0] !== 4'b0000 || blk[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL same_addr: hs=%0d hit=%b idx=%h block=%b, want 1 11 0 0",
                  hs_cnt[0] - h0, hit[0], sidx[0], blk[0]);
      end
      @(posedge clk); #1;
      model_touch(0, 0);
   endtask

   task automatic test_ready_stall();
      do_reset();
      idle_cycle(1, 1'b1, 1'b0, 2'b10, 21'h0, 21'h99, 5);
      n_tests++;
      if (obs_slot[1] !== 2'd0 || obs_new[1] !== 21'h99) begin
         n_fail++;
         $display("FAIL ready_stall: slot=%0d new=%h, want 0 99", obs_slot[1], obs_new[1]);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      en[0] = 1'b1; rv[0] = 2'b01; ra[0] = {21'h0, 21'h77};
      #3;
      n_tests++;
      if (blk[0] !== 1'b1) begin
         n_fail++; $display("FAIL rmw_miss: block=%b, want 1", blk[0]);
      end
      @(posedge clk); #1;
      srdy[0] = 1'b1;
      #3;
      n_tests++;
      if (sv[0] !== 1'b1) begin
         n_fail++; $display("FAIL rmw_issue: valid=%b, want 1", sv[0]);
      end
      @(posedge clk); #1;
      srdy[0] = 1'b0; rst = 1'b1;
      #3;
      n_tests++;
      if (sv[0] !== 1'b0 || blk[0] !== 1'b1) begin
         n_fail++; $display("FAIL rmw_wait: valid=%b block=%b, want 0 1", sv[0], blk[0]);
      end
      @(posedge clk); #1;
      rst = 1'b0; model_reset();
      sdone[0] = 1'b1; en[0] = 1'b0; rv[0] = 2'b11; ra[0] = {21'h00123, 21'h77};
      #3;
      n_tests++;
      if (hit[0] !== 2'b00 || sv[0] !== 1'b0 || blk[0] !== 1'b0 || sslot[0] !== 2'd0 ||
          snew[0] !== 21'd0 || sov[0] !== 1'b0 || sold[0] !== 21'd0) begin
         n_fail++;
         $display("FAIL rmw_after: hit=%b valid=%b block=%b slot=%0d new=%h ov=%b old=%h, want all 0",
                  hit[0], sv[0], blk[0], sslot[0], snew[0], sov[0], sold[0]);
      end
      @(posedge clk); #1;
      sdone[0] = 1'b0;
      #3;
      n_tests++;
      if (sv[0] !== 1'b0 || blk[0] !== 1'b0) begin
         n_fail++; $display("FAIL rmw_late_done: valid=%b block=%b, want 0 0", sv[0], blk[0]);
      end
      @(posedge clk); #1;
      idle_cycle(0, 1'b1, 1'b0, 2'b01, 21'h77, 21'h0, -1);
      n_tests++;
      if (obs_slot[0] !== 2'd0 || obs_ov[0] !== 1'b0 || obs_new[0] !== 21'h77) begin
         n_fail++;
         $display("FAIL rmw_reswap: slot=%0d ov=%b new=%h, want 0 0 77", obs_slot[0], obs_ov[0], obs_new[0]);
      end
   endtask

   task automatic run_rand(int k, int n);
      for (int i = 0; i < n; i++)
         idle_cycle(k, ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0),
                    NP'($urandom_range(0, 3)), rand_addr(), rand_addr(), -1);
   endtask

   task automatic test_random();
      do_reset();
      fork
         run_rand(0, 250);
         run_rand(1, 250);
      join
   endtask

   initial begin
      rst = 1'b1;
      for (int k = 0; k < 2; k++) begin
         en[k] = 1'b0; fl[k] = 1'b0; rv[k] = '0; ra[k] = '0; srdy[k] = 1'b0; sdone[k] = 1'b0;
      end
      @(posedge clk); #1;
      test_reset();
      test_cold_miss();
      test_round_robin();
      test_lru();
      test_same_addr();
      test_ready_stall();
      test_reset_mid_wait();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/block_map_ctrl.md
BLOCK_MAP_CTRL -- requirements
Module: block_map_ctrl

Interface
REQ-001 SHALL have parameter NumPorts, default 2: number of independent request channels.
REQ-002 SHALL have parameter NumSlots, default 4: number of SRAM block slots tracked; power of two, >=2.
REQ-003 SHALL have parameter AddrWidth, default 21: width of a block address.
REQ-004 SHALL have parameter Policy, default 0: replacement mode; 0 = round-robin, 1 = LRU.
REQ-005 SHALL have port clk_i, input, 1: the only clock.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port enable_i, input, 1: swapping enabled.
REQ-008 SHALL have port flush_i, input, 1: invalidate all slots.
REQ-009 SHALL have port req_valid_i, input, NumPorts: per-port request valid.
REQ-010 SHALL have port req_addr_i, input, NumPorts x AddrWidth: per-port block address.
REQ-011 SHALL have port hit_o, output, NumPorts: per-port hit.
REQ-012 SHALL have port slot_idx_o, output, NumPorts x clog2(NumSlots): per-port slot index.
REQ-013 SHALL have port block_o, output, 1: stall all requestors.
REQ-014 SHALL have port swap_valid_o, input-side handshake output, 1: swap command valid.
REQ-015 SHALL have port swap_ready_i, input, 1: swap engine accepts the command.
REQ-016 SHALL have port swap_slot_o, output, clog2(NumSlots): victim slot.
REQ-017 SHALL have port swap_old_addr_o, output, AddrWidth: victim's current address.
REQ-018 SHALL have port swap_old_valid_o, output, 1: victim holds data, so write-back is required.
REQ-019 SHALL have port swap_new_addr_o, output, AddrWidth: block to load.
REQ-020 SHALL have port swap_done_i, input, 1: swap engine finished (single-cycle pulse).

Function
REQ-021 SHALL hold per slot a valid bit and an AddrWidth tag.
REQ-022 SHALL perform lookup combinationally, with zero latency: hit_o[p] = req_valid_i[p] & match in any valid slot; slot_idx_o[p] = index of the matching slot, or 0 if none.
REQ-023 SHALL define miss[p] = enable_i & req_valid_i[p] & ~hit_o[p].
REQ-024 SHALL drive block_o = (state==IDLE & |miss) | (state!=IDLE).
REQ-025 SHALL use the FSM states IDLE, ISSUE, WAIT, FILL.
REQ-026 SHALL, in IDLE with |miss, capture the lowest-index missing port's address as new_addr, select the victim, capture the victim's tag and valid bit, and go to ISSUE.
REQ-027 SHALL select as victim the lowest-index invalid slot; if all slots are valid, the victim is rr_ptr (Policy 0) or the slot with age==NumSlots-1 (Policy 1).
REQ-028 SHALL, in ISSUE, assert swap_valid_o with all swap_* outputs stable; on swap_ready_i, go to WAIT the next cycle.
REQ-029 SHALL, in WAIT, ignore requests; on swap_done_i, go to FILL.
REQ-030 SHALL, in FILL, write tag=new_addr and valid=1 into the victim slot, update the policy state, and return to IDLE.
REQ-031 SHALL, for Policy 0, advance rr_ptr modulo NumSlots in FILL only when the victim was valid.
REQ-032 SHALL, for Policy 1, hold an age of clog2(NumSlots) bits per slot, always forming a permutation of 0..NumSlots-1.
REQ-033 SHALL, on a Policy 1 touch of slot s, set age[s]=0 and increment every age less than the old age[s]; a touch is FILL of the victim, or IDLE with no miss and the lowest-index hitting port.
REQ-034 SHALL, when two ports miss on the same address, perform exactly one swap; after FILL both ports hit.
REQ-035 SHALL complete a swap in progress if enable_i drops; it then issues no new swaps.
REQ-036 SHALL honour flush_i only in IDLE with no miss, clearing all valid bits the next cycle; flush_i is ignored in all other cases.
REQ-037 SHALL ignore swap_done_i outside WAIT and swap_ready_i outside ISSUE.

Reset
REQ-038 SHALL, when rst_i is high at a clock edge, set state=IDLE, clear all valid bits, set rr_ptr=0, set age[i]=i, and zero all captured registers; this applies even mid-swap.
REQ-039 SHALL, after reset, drive swap_valid_o=0, swap_slot_o=0, swap_old_addr_o=0, swap_old_valid_o=0, swap_new_addr_o=0, block_o=|miss, and hit_o=0.

Verification
REQ-040 SHALL cover cold miss: port0 addr 0x00123 -> block_o=1; swap_valid_o next cycle with slot 0, old_valid 0, new 0x00123; ready+done -> hit_o[0]=1, slot_idx_o[0]=0.
REQ-041 SHALL cover round-robin eviction (Policy 0): fill 0x10..0x13, then miss 0x20 -> slot 0, old_addr 0x10, old_valid 1; next miss 0x21 -> slot 1.
REQ-042 SHALL cover LRU eviction (Policy 1): fill 0x10..0x13, hit 0x10, miss 0x20 -> victim is slot 1 (0x11).
REQ-043 SHALL cover same-address misses: both ports miss 0x55 in the same cycle -> exactly one swap_valid_o handshake, then both ports hit the same slot.
REQ-044 SHALL cover ready stall: swap_ready_i held low for 5 cycles -> swap_valid_o and swap_* outputs stable and block_o=1 throughout.
REQ-045 SHALL cover reset mid-WAIT: rst_i asserted in WAIT -> next cycle state IDLE, all hits 0, swap_valid_o=0, and a late swap_done_i is ignored.
